// File: rtl/mdr_arbiter.sv
// mdr_arbiter: round-robin front end that shares one multiply/divide/sqrt (MDR) unit
// between N_REQ requesters. It sequences the MDR operand handshake for the granted
// requester and returns the result, remainder and error status to it.
//
// Ports
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   req[N_REQ]                     per-requester request, held with operands until done
//   req_op[2*N_REQ]                per-requester op: 0=mul, 1=div, 2=sqrt, 3=invalid
//   req_x/req_y[DW*N_REQ]          per-requester operands (y still loaded for sqrt)
//   gnt[N_REQ]                     one-hot grant, high from grant until done
//   done[N_REQ]                    one-cycle completion pulse to the served requester
//   rsp_result/rsp_reminder[DW]    result and remainder of the last transaction
//   rsp_error                      MDR error, invalid op or timeout
//   rsp_timeout                    last transaction was aborted by timeout
//   busy                           arbiter is not idle
//   mdr_start/mdr_load/mdr_op/
//   mdr_data                       operand protocol towards the MDR unit
//   mdr_load_x/mdr_load_y/
//   mdr_ready/mdr_error/
//   mdr_result/mdr_reminder        status and results from the MDR unit
module mdr_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [2*N_REQ-1:0]  req_op,
    input  logic [DW*N_REQ-1:0] req_x,
    input  logic [DW*N_REQ-1:0] req_y,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic [DW-1:0]       rsp_result,
    output logic [DW-1:0]       rsp_reminder,
    output logic                rsp_error,
    output logic                rsp_timeout,
    output logic                busy,
    output logic                mdr_start,
    output logic                mdr_load,
    output logic [1:0]          mdr_op,
    output logic [DW-1:0]       mdr_data,
    input  logic                mdr_load_x,
    input  logic                mdr_load_y,
    input  logic                mdr_ready,
    input  logic                mdr_error,
    input  logic [DW-1:0]       mdr_result,
    input  logic [DW-1:0]       mdr_reminder
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LDX   = 3'd1;
    localparam logic [2:0] PX    = 3'd2;
    localparam logic [2:0] LDY   = 3'd3;
    localparam logic [2:0] PY    = 3'd4;
    localparam logic [2:0] WAIT  = 3'd5;
    localparam logic [2:0] ABORT = 3'd6;
    localparam logic [2:0] RESP  = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [1:0]       op_q, op_d;
    logic [DW-1:0]    x_q, x_d;
    logic [DW-1:0]    y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [DW-1:0]    rsp_result_q, rsp_result_d;
    logic [DW-1:0]    rsp_reminder_q, rsp_reminder_d;
    logic             rsp_error_q, rsp_error_d;
    logic             rsp_timeout_q, rsp_timeout_d;

    logic [1:0]       op_arr [N_REQ];
    logic [DW-1:0]    x_arr  [N_REQ];
    logic [DW-1:0]    y_arr  [N_REQ];
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    cand;
    logic             cnt_hit;

    always_comb begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
            op_arr[k] = req_op[2*k +: 2];
            x_arr[k]  = req_x[DW*k +: DW];
            y_arr[k]  = req_y[DW*k +: DW];
        end
    end

    // Scan from the farthest candidate back to the one just after the pointer,
    // so the last hit is the nearest requester in round-robin order.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            cand = IW'((32'(ptr_q) + k) % N_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign cnt_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        idx_d          = idx_q;
        op_d           = op_q;
        x_d            = x_q;
        y_d            = y_q;
        cnt_d          = cnt_q;
        gnt_d          = gnt_q;
        done_d         = '0;
        rsp_result_d   = rsp_result_q;
        rsp_reminder_d = rsp_reminder_q;
        rsp_error_d    = rsp_error_q;
        rsp_timeout_d  = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                // Skip the done cycle: the served requester still holds req there.
                if (pick_valid && (done_q == '0)) begin
                    idx_d           = pick_idx;
                    op_d            = op_arr[pick_idx];
                    x_d             = x_arr[pick_idx];
                    y_d             = y_arr[pick_idx];
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    cnt_d           = '0;
                    rsp_timeout_d   = 1'b0;
                    if (op_arr[pick_idx] == 2'd3) begin
                        state_d        = RESP;
                        rsp_error_d    = 1'b1;
                        rsp_result_d   = '0;
                        rsp_reminder_d = '0;
                    end else begin
                        state_d = LDX;
                    end
                end
            end
            LDX: begin
                if (mdr_load_x) begin
                    state_d = PX;
                end else if (cnt_hit) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PX: begin
                state_d = LDY;
                cnt_d   = '0;
            end
            LDY: begin
                if (mdr_load_y) begin
                    state_d = PY;
                end else if (cnt_hit) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PY: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (mdr_ready) begin
                    state_d        = RESP;
                    rsp_result_d   = mdr_result;
                    rsp_reminder_d = mdr_reminder;
                    rsp_error_d    = mdr_error;
                end else if (cnt_hit) begin
                    state_d = ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ABORT: begin
                state_d        = RESP;
                rsp_result_d   = '0;
                rsp_reminder_d = '0;
                rsp_error_d    = 1'b1;
                rsp_timeout_d  = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
                done_d  = gnt_q;
                gnt_d   = '0;
                ptr_d   = idx_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= IW'(N_REQ - 1);
            idx_q          <= '0;
            op_q           <= '0;
            x_q            <= '0;
            y_q            <= '0;
            cnt_q          <= '0;
            gnt_q          <= '0;
            done_q         <= '0;
            rsp_result_q   <= '0;
            rsp_reminder_q <= '0;
            rsp_error_q    <= 1'b0;
            rsp_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            idx_q          <= idx_d;
            op_q           <= op_d;
            x_q            <= x_d;
            y_q            <= y_d;
            cnt_q          <= cnt_d;
            gnt_q          <= gnt_d;
            done_q         <= done_d;
            rsp_result_q   <= rsp_result_d;
            rsp_reminder_q <= rsp_reminder_d;
            rsp_error_q    <= rsp_error_d;
            rsp_timeout_q  <= rsp_timeout_d;
        end
    end

    // MDR-side outputs are decoded from the state register only (Moore).
    assign mdr_start = (state_q == LDX) || (state_q == PX) || (state_q == LDY) ||
                       (state_q == PY) || (state_q == WAIT);
    assign mdr_load  = (state_q == PX) || (state_q == PY);
    assign mdr_op    = mdr_start ? op_q : 2'd0;

    always_comb begin
        mdr_data = '0;
        if ((state_q == LDX) || (state_q == PX)) begin
            mdr_data = x_q;
        end else if ((state_q == LDY) || (state_q == PY)) begin
            mdr_data = y_q;
        end
    end

    assign busy         = (state_q != IDLE);
    assign gnt          = gnt_q;
    assign done         = done_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_reminder = rsp_reminder_q;
    assign rsp_error    = rsp_error_q;
    assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: tb/tb_mdr_arbiter.sv
// Bench for mdr_arbiter: a small MDR responder, requester drivers and a
// round-robin/arithmetic reference model checked every falling clock edge.
module tb_mdr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req;
    logic [2*N-1:0]  req_op;
    logic [DW*N-1:0] req_x, req_y;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rsp_result, rsp_reminder;
    logic            rsp_error, rsp_timeout, busy, mdr_start, mdr_load;
    logic [1:0]      mdr_op;
    logic [DW-1:0]   mdr_data;
    logic            mdr_load_x, mdr_load_y, mdr_ready, mdr_error;
    logic [DW-1:0]   mdr_result, mdr_reminder;

    logic [1:0]      r_op [N];
    logic [DW-1:0]   r_x  [N];
    logic [DW-1:0]   r_y  [N];
    int              rem_cnt [N];

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    int cyc = 0;
    int m_last = N - 1;
    int m_cur = -1;
    int grant_cyc = 0;
    logic [N-1:0] prev_gnt = '0;
    logic [N-1:0] req_seen = '0;
    int order_q[$];
    bit stuck = 1'b0;
    int phase = 0;
    int dly = 0;

    mdr_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .done(done), .rsp_result(rsp_result), .rsp_reminder(rsp_reminder),
        .rsp_error(rsp_error), .rsp_timeout(rsp_timeout), .busy(busy),
        .mdr_start(mdr_start), .mdr_load(mdr_load), .mdr_op(mdr_op), .mdr_data(mdr_data),
        .mdr_load_x(mdr_load_x), .mdr_load_y(mdr_load_y), .mdr_ready(mdr_ready),
        .mdr_error(mdr_error), .mdr_result(mdr_result), .mdr_reminder(mdr_reminder)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_op = '0;
        req_x  = '0;
        req_y  = '0;
        for (int k = 0; k < N; k++) begin
            req_op[2*k +: 2] = r_op[k];
            req_x[DW*k +: DW] = r_x[k];
            req_y[DW*k +: DW] = r_y[k];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // What a correct MDR returns: mul gives low/high product halves,
    // div quotient/remainder (error on y=0), sqrt floor root and x-root^2.
    function automatic void model_op(input logic [1:0] op, input logic [DW-1:0] x,
                                     input logic [DW-1:0] y, output logic [DW-1:0] res,
                                     output logic [DW-1:0] rem, output logic err);
        logic [2*DW-1:0] p;
        int r;
        res = '0;
        rem = '0;
        err = 1'b0;
        case (op)
            2'd0: begin
                p   = {16'd0, x} * {16'd0, y};
                res = p[DW-1:0];
                rem = p[2*DW-1:DW];
            end
            2'd1: begin
                if (y == '0) err = 1'b1;
                else begin
                    res = x / y;
                    rem = x % y;
                end
            end
            2'd2: begin
                r = 0;
                while ((r + 1) * (r + 1) <= int'(x)) r++;
                res = DW'(r);
                rem = x - DW'(r * r);
            end
            default: err = 1'b1;
        endcase
    endfunction

    // Requesters: keep req high while transactions remain.
    initial begin : req_driver
        req = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) req[k] = (rem_cnt[k] > 0) && !rst;
        end
    end

    // Behavioural MDR unit with fixed handshake delays.
    initial begin : mdr_model
        logic [DW-1:0] cap_x, cap_y, res, rem;
        logic err;
        mdr_load_x = 1'b0; mdr_load_y = 1'b0; mdr_ready = 1'b0; mdr_error = 1'b0;
        mdr_result = '0; mdr_reminder = '0;
        cap_x = '0; cap_y = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                phase = 0;
                mdr_load_x = 1'b0; mdr_load_y = 1'b0; mdr_ready = 1'b0;
            end else begin
                case (phase)
                    0: if (mdr_start) begin phase = 1; dly = 1; end
                    1: if (dly > 0) dly--; else begin mdr_load_x = 1'b1; phase = 2; end
                    2: if (mdr_load) begin
                        if (m_cur >= 0) begin
                            chk("mdr_x", 32'(mdr_data), 32'(r_x[m_cur]));
                            chk("mdr_op", 32'(mdr_op), 32'(r_op[m_cur]));
                        end
                        cap_x = mdr_data; mdr_load_x = 1'b0; phase = 3; dly = 2;
                    end
                    3: if (dly > 0) dly--; else begin mdr_load_y = 1'b1; phase = 4; end
                    4: if (mdr_load) begin
                        if (m_cur >= 0) chk("mdr_y", 32'(mdr_data), 32'(r_y[m_cur]));
                        cap_y = mdr_data; mdr_load_y = 1'b0; phase = 5; dly = 3;
                    end
                    5: if (!stuck) begin
                        if (dly > 0) dly--;
                        else begin
                            model_op(mdr_op, cap_x, cap_y, res, rem, err);
                            mdr_result = res; mdr_reminder = rem; mdr_error = err;
                            mdr_ready = 1'b1; phase = 6;
                        end
                    end
                    default: begin
                        mdr_ready = 1'b0;
                        if (!mdr_start) phase = 0;
                    end
                endcase
                if (phase >= 1 && phase <= 5) begin
                    if (!stuck) chk("start_held", 32'(mdr_start), 32'd1);
                    if (!mdr_start) begin
                        phase = 0; mdr_load_x = 1'b0; mdr_load_y = 1'b0;
                    end
                end
            end
        end
    end

    // Reference model and per-cycle comparison.
    always @(negedge clk) begin
        logic [DW-1:0] e_res, e_rem;
        logic e_err, e_to;
        int e_idx;
        cyc++;
        if (rst) begin
            m_last = N - 1; m_cur = -1; prev_gnt = '0; req_seen = '0;
        end else begin
            chk("busy_vs_gnt", 32'(busy), 32'(gnt != '0));
            chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            if (m_cur >= 0 && r_op[m_cur] == 2'd3) chk("inv_no_start", 32'(mdr_start), 32'd0);
            if (done != '0) begin
                if (m_cur < 0) chk("done_unexpected", 32'(done), 32'd0);
                else begin
                    chk("done_idx", 32'(done), 32'(1 << m_cur));
                    if (stuck) begin
                        e_res = '0; e_rem = '0; e_err = 1'b1; e_to = 1'b1;
                    end else begin
                        model_op(r_op[m_cur], r_x[m_cur], r_y[m_cur], e_res, e_rem, e_err);
                        e_to = 1'b0;
                    end
                    chk("rsp_result", 32'(rsp_result), 32'(e_res));
                    chk("rsp_reminder", 32'(rsp_reminder), 32'(e_rem));
                    chk("rsp_error", 32'(rsp_error), 32'(e_err));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e_to));
                    if (r_op[m_cur] == 2'd3) chk("inv_latency", 32'(cyc - grant_cyc), 32'd1);
                    m_last = m_cur; rem_cnt[m_cur]--; m_cur = -1; n_done++;
                end
            end
            if (gnt != '0 && prev_gnt == '0) begin
                e_idx = rr_pick(req_seen, m_last);
                chk("grant_rr", 32'(gnt), (e_idx < 0) ? 32'd0 : 32'(1 << e_idx));
                chk("timeout_clr_on_grant", 32'(rsp_timeout), 32'd0);
                m_cur = e_idx; grant_cyc = cyc;
                order_q.push_back(e_idx);
            end
            prev_gnt = gnt;
            req_seen = req;
        end
    end

    task automatic serve(input int cnt, input int budget, input string name);
        int target = n_done + cnt;
        int k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(n_done), 32'(target));
        repeat (3) @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [DW-1:0] x,
                           input logic [DW-1:0] y, input int n);
        r_op[i] = op; r_x[i] = x; r_y[i] = y; rem_cnt[i] = n;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_start"}, 32'(mdr_start), 32'd0);
        chk({tag, "_load"}, 32'(mdr_load), 32'd0);
        chk({tag, "_op"}, 32'(mdr_op), 32'd0);
        chk({tag, "_data"}, 32'(mdr_data), 32'd0);
        chk({tag, "_result"}, 32'(rsp_result), 32'd0);
        chk({tag, "_reminder"}, 32'(rsp_reminder), 32'd0);
        chk({tag, "_error"}, 32'(rsp_error), 32'd0);
        chk({tag, "_timeout"}, 32'(rsp_timeout), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int exp_a[4];
        int exp_b[4];
        int k;
        int saved;
        for (int i = 0; i < N; i++) begin
            r_op[i] = '0; r_x[i] = '0; r_y[i] = '0; rem_cnt[i] = 0;
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 3*5
        set_req(0, 2'd0, 16'd3, 16'd5, 1);
        serve(1, 100, "t1_done");
        chk("t1_result15", 32'(rsp_result), 32'd15);
        chk("t1_error0", 32'(rsp_error), 32'd0);

        // 172/3
        set_req(1, 2'd1, 16'd172, 16'd3, 1);
        serve(1, 100, "t2_done");
        chk("t2_result57", 32'(rsp_result), 32'd57);
        chk("t2_rem1", 32'(rsp_reminder), 32'd1);

        // sqrt(314)
        set_req(2, 2'd2, 16'd314, 16'd0, 1);
        serve(1, 100, "t3_done");
        chk("t3_result17", 32'(rsp_result), 32'd17);
        chk("t3_rem25", 32'(rsp_reminder), 32'd25);

        // Two requesters competing, two transactions each.
        order_q.delete();
        set_req(0, 2'd0, 16'd7, 16'd9, 2);
        set_req(2, 2'd1, 16'd100, 16'd7, 2);
        serve(4, 400, "t4a_done");
        exp_a = '{0, 2, 0, 2};
        chk("t4a_count", 32'(order_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < order_q.size()) chk("t4a_order", 32'(order_q[i]), 32'(exp_a[i]));

        // Leave the pointer on requester 3, then all four at once.
        set_req(3, 2'd0, 16'd300, 16'd400, 1);
        serve(1, 100, "t4p_done");
        chk("t4p_result", 32'(rsp_result), 32'd54464);
        chk("t4p_rem", 32'(rsp_reminder), 32'd1);
        order_q.delete();
        set_req(0, 2'd0, 16'd2, 16'd3, 1);
        set_req(1, 2'd1, 16'd9, 16'd4, 1);
        set_req(2, 2'd2, 16'd81, 16'd0, 1);
        set_req(3, 2'd1, 16'd65535, 16'd255, 1);
        serve(4, 400, "t4b_done");
        exp_b = '{0, 1, 2, 3};
        chk("t4b_count", 32'(order_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < order_q.size()) chk("t4b_order", 32'(order_q[i]), 32'(exp_b[i]));
        chk("t4b_result257", 32'(rsp_result), 32'd257);

        // Invalid op and divide by zero.
        set_req(1, 2'd3, 16'd5, 16'd6, 1);
        serve(1, 100, "t5a_done");
        chk("t5a_error", 32'(rsp_error), 32'd1);
        set_req(2, 2'd1, 16'd50, 16'd0, 1);
        serve(1, 100, "t5b_done");
        chk("t5b_error", 32'(rsp_error), 32'd1);

        // Ready never arrives.
        stuck = 1'b1;
        set_req(0, 2'd0, 16'd2, 16'd2, 1);
        serve(1, 300, "t6a_done");
        chk("t6a_timeout", 32'(rsp_timeout), 32'd1);
        chk("t6a_error", 32'(rsp_error), 32'd1);
        chk("t6a_result0", 32'(rsp_result), 32'd0);
        stuck = 1'b0;

        // Reset while waiting for ready.
        stuck = 1'b1;
        set_req(3, 2'd0, 16'd11, 16'd13, 1);
        k = 0;
        while (phase != 5 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t6b_reach_wait", 32'(phase), 32'd5);
        repeat (5) @(negedge clk);
        saved = n_done;
        #2 rst = 1'b1;
        rem_cnt[3] = 0;
        #1 chk_all_zero("t6b_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6b_no_done", 32'(n_done), 32'(saved));
        set_req(3, 2'd0, 16'd11, 16'd13, 1);
        serve(1, 100, "t6c_done");
        chk("t6c_result143", 32'(rsp_result), 32'd143);
        chk("t6c_error0", 32'(rsp_error), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
